// File: rtl/booth_arb_pkg.sv
// Shared types and constants for the booth arbiter.
// Optional feature macro used by booth_arbiter: BOOTH_STATS_EN (per-booth ack counters).
package booth_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ISSUE = 3'd2,
        ACK   = 3'd3,
        NAK   = 3'd4
    } state_t;

    localparam int CAND_NONE = 0;
    localparam int STAT_W    = 12;

endpackage

// File: rtl/booth_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible booth at or after ptr, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan N positions starting from ptr; the first eligible one wins.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && eligible[j]) begin
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_arbiter.sv
// Round-robin arbiter sharing one ballot port of the tally among voting booths.
// State table:
//   IDLE  | waiting; with Close high, naks eligible booths one per cycle
//   ARB   | pick booth, latch its candidate, disarm it
//   ISSUE | ballot offered to tally, timeout counter running
//   ACK   | one-cycle ack pulse to granted booth
//   NAK   | one-cycle nak pulse (candidate 0 or timeout)
// Optional: define BOOTH_STATS_EN to add the booth_votes output (12-bit saturating
// ack count per booth).
module booth_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NUM_BOOTH = 4,
    parameter int CAND_W    = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          Power,
    input  logic                          Close,
    input  logic [NUM_BOOTH-1:0]          booth_req,
    input  logic [NUM_BOOTH*CAND_W-1:0]   booth_cand,
    output logic [NUM_BOOTH-1:0]          booth_ack,
    output logic [NUM_BOOTH-1:0]          booth_nak,
    output logic                          vote_valid,
    output logic [CAND_W-1:0]             vote_cand,
    input  logic                          vote_ready,
    output logic                          busy,
    output logic                          timeout_err
`ifdef BOOTH_STATS_EN
    ,
    output logic [NUM_BOOTH*STAT_W-1:0]   booth_votes
`endif
);

    localparam int IDX_W = $clog2(NUM_BOOTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                 state, state_nxt;
    logic [NUM_BOOTH-1:0]   armed;
    logic [NUM_BOOTH-1:0]   eligible;
    logic [NUM_BOOTH-1:0]   pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_id;
    logic [CAND_W-1:0]      cand_q;
    logic [CAND_W-1:0]      cand_sel;
    logic [CNT_W-1:0]       cnt;
    logic                   arb_take;
    logic                   close_nak;
    logic                   timeout_hit;

    assign eligible   = booth_req & armed;
    assign cand_sel   = booth_cand[int'(pick_idx)*CAND_W +: CAND_W];
    assign vote_cand  = cand_q;
    assign busy       = (state != IDLE);

    rr_pick #(.N(NUM_BOOTH), .IDX_W(IDX_W)) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (Power) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        vote_valid  = 1'b0;
        booth_ack   = '0;
        booth_nak   = '0;
        arb_take    = 1'b0;
        close_nak   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    if (!Close) begin
                        state_nxt = ARB;
                    end else begin
                        booth_nak = pick_grant;
                        close_nak = 1'b1;
                    end
                end
            end
            ARB: begin
                if (pick_any) begin
                    arb_take = 1'b1;
                    if (cand_sel == CAND_W'(CAND_NONE)) state_nxt = NAK;
                    else                                state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                vote_valid = 1'b1;
                if (vote_ready) begin
                    state_nxt = ACK;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = NAK;
                end
            end
            ACK: begin
                booth_ack[grant_id] = 1'b1;
                state_nxt           = IDLE;
            end
            NAK: begin
                booth_nak[grant_id] = 1'b1;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arming, grant latch, timeout counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (Power) begin
            armed       <= '1;
            grant_id    <= '0;
            cand_q      <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            armed <= (armed & ~((arb_take || close_nak) ? pick_grant : '0)) | ~booth_req;
            if (arb_take) begin
                grant_id <= pick_idx;
                cand_q   <= cand_sel;
            end
            if (state == ISSUE && !vote_ready) cnt <= cnt + 1'b1;
            else                               cnt <= '0;
            if (timeout_hit) timeout_err <= 1'b1;
            if (state == ACK || state == NAK) begin
                if (grant_id == IDX_W'(NUM_BOOTH - 1)) rr_ptr <= '0;
                else                                   rr_ptr <= grant_id + 1'b1;
            end
        end
    end

`ifdef BOOTH_STATS_EN
    // Saturating per-booth count of accepted votes.
    always_ff @(posedge clk) begin
        if (Power) begin
            booth_votes <= '0;
        end else begin
            for (int b = 0; b < NUM_BOOTH; b++) begin
                if (booth_ack[b] && booth_votes[b*STAT_W +: STAT_W] != {STAT_W{1'b1}})
                    booth_votes[b*STAT_W +: STAT_W] <= booth_votes[b*STAT_W +: STAT_W] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed self-checking bench for booth_arbiter (4 booths, 4-bit candidates, TIMEOUT=4).
module tb_booth_arbiter;

    logic        clk = 1'b0;
    logic        Power;
    logic        Close;
    logic [3:0]  booth_req;
    logic [15:0] booth_cand;
    logic [3:0]  booth_ack;
    logic [3:0]  booth_nak;
    logic        vote_valid;
    logic [3:0]  vote_cand;
    logic        vote_ready;
    logic        busy;
    logic        timeout_err;
`ifdef BOOTH_STATS_EN
    logic [47:0] booth_votes;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_arbiter #(.NUM_BOOTH(4), .CAND_W(4), .TIMEOUT(4)) dut (
        .clk         (clk),
        .Power       (Power),
        .Close       (Close),
        .booth_req   (booth_req),
        .booth_cand  (booth_cand),
        .booth_ack   (booth_ack),
        .booth_nak   (booth_nak),
        .vote_valid  (vote_valid),
        .vote_cand   (vote_cand),
        .vote_ready  (vote_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
`ifdef BOOTH_STATS_EN
        ,
        .booth_votes (booth_votes)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic power_pulse();
        Power = 1'b1;
        tick();
        Power = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (!vote_valid && n < 10) begin
            tick();
            n++;
        end
        ok = vote_valid;
    endtask

    task automatic test_reset();
        Power = 1'b1; Close = 1'b0; booth_req = '0; booth_cand = '0; vote_ready = 1'b0;
        tick();
        tick();
        Power = 1'b0;
        checks++; if (vote_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vote_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (booth_ack !== 4'b0 || booth_nak !== 4'b0) begin errors++; $display("FAIL reset_acknak: got ack=%b nak=%b want 0", booth_ack, booth_nak); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
        checks++; if (vote_cand !== 4'd0) begin errors++; $display("FAIL reset_cand: got %0d want 0", vote_cand); end
    endtask

    task automatic test_single();
        booth_cand[11:8] = 4'd5; booth_req = 4'b0100; vote_ready = 1'b1;
        tick();
        checks++; if (vote_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_arb: got valid=%b busy=%b want 0/1", vote_valid, busy); end
        tick();
        checks++; if (vote_valid !== 1'b1 || vote_cand !== 4'd5) begin errors++; $display("FAIL single_issue: got valid=%b cand=%0d want 1/5", vote_valid, vote_cand); end
        tick();
        checks++; if (booth_ack !== 4'b0100 || vote_valid !== 1'b0) begin errors++; $display("FAIL single_ack: got ack=%b valid=%b want 0100/0", booth_ack, vote_valid); end
        booth_req = '0;
        tick();
        checks++; if (booth_ack !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got ack=%b busy=%b want 0/0", booth_ack, busy); end
    endtask

    task automatic test_all_booths();
        bit ok;
        logic [3:0] exp_ack;
        power_pulse();
        booth_cand = {4'd4, 4'd3, 4'd2, 4'd1}; booth_req = 4'b1111; vote_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            checks++; if (!ok) begin errors++; $display("FAIL all_valid%0d: got no vote_valid want vote_valid", k); end
            checks++; if (vote_cand !== 4'(k + 1)) begin errors++; $display("FAIL all_cand%0d: got %0d want %0d", k, vote_cand, k + 1); end
            tick();
            exp_ack = 4'b0001 << k;
            checks++; if (booth_ack !== exp_ack) begin errors++; $display("FAIL all_ack%0d: got %b want %b", k, booth_ack, exp_ack); end
        end
        booth_req = '0;
        tick();
        booth_req = 4'b1001;
        wait_valid(ok);
        checks++; if (!ok || vote_cand !== 4'd1) begin errors++; $display("FAIL all_ptr_wrap: got valid=%b cand=%0d want 1/1", vote_valid, vote_cand); end
        tick();
        checks++; if (booth_ack !== 4'b0001) begin errors++; $display("FAIL all_ptr_ack: got %b want 0001", booth_ack); end
        booth_req = '0;
        tick();
        tick();
    endtask

    task automatic test_hold();
        int n;
        booth_cand[7:4] = 4'd6; booth_req = 4'b0010; vote_ready = 1'b1;
        n = 0;
        repeat (20) begin tick(); if (booth_ack[1]) n++; end
        checks++; if (n != 1) begin errors++; $display("FAIL hold_once: got %0d acks want 1", n); end
        booth_req = '0;
        tick();
        booth_req = 4'b0010;
        n = 0;
        repeat (10) begin tick(); if (booth_ack[1]) n++; end
        checks++; if (n != 1) begin errors++; $display("FAIL hold_rearm: got %0d acks want 1", n); end
        booth_req = '0;
        tick();
        tick();
    endtask

    task automatic test_cand_zero();
        int nv, nn, na;
        booth_cand[3:0] = 4'd0; booth_req = 4'b0001; vote_ready = 1'b1;
        nv = 0; nn = 0; na = 0;
        repeat (8) begin
            tick();
            if (vote_valid) nv++;
            if (booth_nak[0]) nn++;
            if (booth_ack != 4'b0) na++;
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL zero_valid: got %0d cycles want 0", nv); end
        checks++; if (nn != 1 || na != 0) begin errors++; $display("FAIL zero_nak: got nak=%0d ack=%0d want 1/0", nn, na); end
        booth_req = '0;
        tick();
    endtask

    task automatic test_timeout();
        int nv, nn, na;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pre: got %b want 0", timeout_err); end
        booth_cand[15:12] = 4'd7; booth_req = 4'b1000; vote_ready = 1'b0;
        nv = 0; nn = 0; na = 0;
        repeat (15) begin
            tick();
            if (vote_valid) nv++;
            if (booth_nak[3]) nn++;
            if (booth_ack != 4'b0) na++;
        end
        checks++; if (nv != 4) begin errors++; $display("FAIL to_valid_cycles: got %0d want 4", nv); end
        checks++; if (nn != 1 || na != 0) begin errors++; $display("FAIL to_nak: got nak=%0d ack=%0d want 1/0", nn, na); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", timeout_err); end
        booth_req = '0;
        repeat (5) tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_close();
        logic [3:0] seq [2];
        int nseq, nv, nb;
`ifdef BOOTH_STATS_EN
        logic [47:0] votes_before;
        votes_before = booth_votes;
`endif
        seq[0] = '0; seq[1] = '0; nseq = 0; nv = 0; nb = 0;
        booth_cand = {4'd2, 4'd3, 4'd4, 4'd5}; vote_ready = 1'b1;
        Close = 1'b1; booth_req = 4'b1010;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (booth_nak != 4'b0) begin
                if (nseq < 2) seq[nseq] = booth_nak;
                nseq++;
            end
            if (vote_valid) nv++;
            if (busy) nb++;
            tick();
        end
        checks++; if (nseq != 2) begin errors++; $display("FAIL close_count: got %0d naks want 2", nseq); end
        checks++; if (seq[0] !== 4'b0010) begin errors++; $display("FAIL close_first: got %b want 0010", seq[0]); end
        checks++; if (seq[1] !== 4'b1000) begin errors++; $display("FAIL close_second: got %b want 1000", seq[1]); end
        checks++; if (nv != 0 || nb != 0) begin errors++; $display("FAIL close_idle: got valid=%0d busy=%0d want 0/0", nv, nb); end
`ifdef BOOTH_STATS_EN
        checks++; if (booth_votes !== votes_before) begin errors++; $display("FAIL close_stats: got %h want %h", booth_votes, votes_before); end
`endif
        Close = 1'b0; booth_req = '0;
        tick();
    endtask

    task automatic test_power_mid();
        bit ok;
        int n;
        booth_cand[3:0] = 4'd9; booth_req = 4'b0001; vote_ready = 1'b0;
        wait_valid(ok);
        checks++; if (!ok || vote_cand !== 4'd9) begin errors++; $display("FAIL pwr_issue: got valid=%b cand=%0d want 1/9", vote_valid, vote_cand); end
        Power = 1'b1; booth_req = '0;
        tick();
        Power = 1'b0;
        checks++; if (vote_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pwr_drop: got valid=%b busy=%b want 0/0", vote_valid, busy); end
        n = 0;
        repeat (3) begin tick(); if (booth_ack != 4'b0 || booth_nak != 4'b0) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL pwr_no_pulse: got %0d pulses want 0", n); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL pwr_clear_err: got %b want 0", timeout_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_booths();
        test_hold();
        test_cand_zero();
        test_timeout();
        test_close();
        test_power_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
